// File: rtl/uart_responder_pkg.sv
// uart_responder_pkg: shared FSM state encodings, clock/baud defaults and the
// tick-divisor helper for the serial-port responder.
package uart_responder_pkg;

  localparam int CLK_50M   = 50_000_000;
  localparam int BAUD_9600 = 9600;
  localparam int OVS_16    = 16;

  // Common encoding for both the TX and the RX frame FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Oversample tick divisor, truncated.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divisor producing a one-cycle oversample tick
// every DIV clocks, shared by the receiver and the transmitter.
module uart_tick_gen #(
  parameter int DIV = 325
) (
  input  logic memi_clk,
  input  logic memi_rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; cleared by reset.
  // NOTE: sequential state uses <= so every flop sees pre-edge values no matter the statement order.
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_responder.sv
// uart_responder: device side of the CPU serial-port handshake. Answers the
// active-low wrn/rdn strobes, serialises written bytes onto txd (8N1) and
// deserialises rxd into a one-deep receive holding register.
// Optional build macro UART_LOOPBACK_EN adds a loopback input that routes the
// internal TX line into the RX synchroniser and holds txd high.
module uart_responder
  import uart_responder_pkg::*;
#(
  parameter int CLK_HZ = CLK_50M,
  parameter int BAUD   = BAUD_9600,
  parameter int OVS    = OVS_16
) (
  input  logic       memi_clk,
  input  logic       memi_rst,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       overrun,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       rxd,
  output logic       txd
);

  localparam int            DIV      = calc_div(CLK_HZ, BAUD, OVS);
  localparam int            OW       = $clog2(OVS);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
  localparam logic [OW-1:0] OVS_MID  = OW'(OVS / 2 - 1);

  logic tick;

  uart_tick_gen #(.DIV(DIV)) u_tick_gen (
    .memi_clk (memi_clk),
    .memi_rst (memi_rst),
    .tick     (tick)
  );

  // ---------------------------------------------------------------- strobes
  logic wrn_q, rdn_q;
  logic wr_fall, rd_rise;

  // Previous strobe samples; idle high so reset release is not an edge.
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= wrn;
      rdn_q <= rdn;
    end
  end

  assign wr_fall  = wrn_q & ~wrn;
  assign rd_rise  = ~rdn_q & rdn;
  assign rdata_oe = ~rdn;

  // --------------------------------------------------------------- transmit
  uart_state_t   tx_state, tx_state_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic [2:0]    tx_idx, tx_idx_d;
  logic [OW-1:0] tx_ovs, tx_ovs_d;
  logic [7:0]    thr, thr_d;
  logic          tbre_d, tsre_d;
  logic          tx_line, tx_line_d;
  logic          tx_reload, wr_accept, tx_last;

  assign tx_last = tick && (tx_ovs == OVS_LAST);

  // TX next state: frame sequencing, holding-register reload and write accept.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    tx_state_d = tx_state;
    tx_shift_d = tx_shift;
    tx_idx_d   = tx_idx;
    tx_ovs_d   = tx_ovs;
    thr_d      = thr;
    tbre_d     = tbre;
    tsre_d     = tsre;
    tx_reload  = 1'b0;
    wr_accept  = 1'b0;
    tx_line_d  = 1'b1;

    if (tick) begin
      tx_ovs_d = tx_ovs + 1'b1;
    end

    case (tx_state)
      ST_IDLE: begin
        if (!tbre) begin
          tx_reload  = 1'b1;
          tsre_d     = 1'b0;
          tx_ovs_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_last) begin
          tx_ovs_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_last) begin
          tx_ovs_d = '0;
          if (tx_idx == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_idx_d = tx_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tx_last) begin
          tx_ovs_d = '0;
          if (!tbre) begin
            // Back-to-back: next start bit follows the stop bit directly.
            tx_reload  = 1'b1;
            tx_state_d = ST_START;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = ST_IDLE;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    if (tx_reload) begin
      tx_shift_d = thr;
    end

    // A reload in this cycle frees the holding register, so a coincident
    // write is accepted rather than dropped.
    wr_accept = wr_fall && (tbre || tx_reload);
    if (wr_accept) begin
      thr_d  = wdata;
      tbre_d = 1'b0;
    end else if (tx_reload) begin
      tbre_d = 1'b1;
    end

    // Registered line level, decoded from the state being entered.
    case (tx_state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_shift_d[tx_idx_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // TX state register; reset aborts any frame and drives the line high at once.
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      tx_state <= ST_IDLE;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_ovs   <= '0;
      thr      <= '0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_shift <= tx_shift_d;
      tx_idx   <= tx_idx_d;
      tx_ovs   <= tx_ovs_d;
      thr      <= thr_d;
      tbre     <= tbre_d;
      tsre     <= tsre_d;
      tx_line  <= tx_line_d;
    end
  end

  // ---------------------------------------------------------------- receive
  logic rx_src, rx_meta, rx_sync, rx_prev;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : rxd;
  assign txd    = loopback ? 1'b1 : tx_line;
`else
  assign rx_src = rxd;
  assign txd    = tx_line;
`endif

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_state_t   rx_state, rx_state_d;
  logic [OW-1:0] rx_ovs, rx_ovs_d;
  logic [2:0]    rx_idx, rx_idx_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic [7:0]    rdata_d;
  logic          data_ready_d, overrun_d;
  logic          frame_ok, rx_bit_due;

  assign rx_bit_due = tick && (rx_ovs == OVS_LAST);

  // RX next state: start qualification, mid-bit sampling and holding register.
  always_comb begin
    rx_state_d   = rx_state;
    rx_ovs_d     = rx_ovs;
    rx_idx_d     = rx_idx;
    rx_shift_d   = rx_shift;
    rdata_d      = rdata;
    data_ready_d = data_ready;
    overrun_d    = overrun;
    frame_ok     = 1'b0;

    if (tick) begin
      rx_ovs_d = rx_ovs + 1'b1;
    end

    case (rx_state)
      ST_IDLE: begin
        rx_ovs_d = '0;
        if (rx_prev && !rx_sync) begin
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        // Half a bit in: still low means a real start bit, else a glitch.
        if (tick && (rx_ovs == OVS_MID)) begin
          rx_ovs_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_bit_due) begin
          rx_ovs_d   = '0;
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          if (rx_idx == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (rx_bit_due) begin
          rx_ovs_d   = '0;
          frame_ok   = rx_sync;
          rx_state_d = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase

    // A read completing alongside a new frame makes room: the new byte wins.
    if (frame_ok && (!data_ready || rd_rise)) begin
      rdata_d      = rx_shift;
      data_ready_d = 1'b1;
      overrun_d    = 1'b0;
    end else if (frame_ok) begin
      overrun_d = 1'b1;
    end else if (rd_rise) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // RX state register and receive holding register.
  always_ff @(posedge memi_clk or negedge memi_rst) begin
    if (!memi_rst) begin
      rx_state   <= ST_IDLE;
      rx_ovs     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rdata      <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_ovs     <= rx_ovs_d;
      rx_idx     <= rx_idx_d;
      rx_shift   <= rx_shift_d;
      rdata      <= rdata_d;
      data_ready <= data_ready_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_responder.sv
// tb_uart_responder: directed bench for uart_responder. Runs with a scaled
// clock (DIV = 614400/(9600*16) = 4, so one bit = 64 clocks) to keep frames short.
module tb_uart_responder;

  localparam int CLK_HZ = 614_400;
  localparam int BAUD   = 9600;
  localparam int OVS    = 16;
  localparam int BIT    = 64;

  logic       memi_clk = 1'b0;
  logic       memi_rst = 1'b0;
  logic       wrn      = 1'b1;
  logic       rdn      = 1'b1;
  logic [7:0] wdata    = 8'h00;
  logic       rxd      = 1'b1;
  logic [7:0] rdata;
  logic       rdata_oe, data_ready, tbre, tsre, overrun, txd;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int frame_t0 = 0;

  uart_responder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .memi_clk   (memi_clk),
    .memi_rst   (memi_rst),
    .wrn        (wrn),
    .rdn        (rdn),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_oe   (rdata_oe),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .overrun    (overrun),
`ifdef UART_LOOPBACK_EN
    .loopback   (loopback),
`endif
    .rxd        (rxd),
    .txd        (txd)
  );

  always #5 memi_clk = ~memi_clk;

  always @(posedge memi_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge memi_clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  // Bounded wait for txd to reach val; caller checks txd afterwards.
  task automatic wait_txd(input logic val, input int limit, output int when);
    int n;
    n = 0;
    while (txd !== val && n < limit) begin
      step(1);
      n++;
    end
    when = cyc;
  endtask

  // Sample txd mid-bit for the first nbits of an 8N1 frame starting at frame_t0.
  task automatic check_bits(input logic [7:0] b, input int nbits, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      step_to(frame_t0 + BIT * j + 30);
      check($sformatf("%s_bit%0d", tag, j), 32'(txd), 32'(fr[j]));
    end
  endtask

  // Drive one 8N1 frame on rxd with the given stop-bit level.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rxd = fr[j];
      step(BIT);
    end
    rxd = 1'b1;
  endtask

  task automatic do_read(output logic [7:0] val, output logic oe);
    rdn = 1'b0;
    step(1);
    val = rdata;
    oe  = rdata_oe;
    rdn = 1'b1;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic       oe;
    logic       seen_low;
    int         t1, t2;

    // ---- reset values
    step(3);
    check("rst_txd",        32'(txd),        32'd1);
    check("rst_tbre",       32'(tbre),       32'd1);
    check("rst_tsre",       32'(tsre),       32'd1);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_rdata",      32'(rdata),      32'h00);
    check("rst_rdata_oe",   32'(rdata_oe),   32'd0);
    memi_rst = 1'b1;
    step(5);

    // ---- single byte out: A5
    wdata = 8'hA5;
    wrn   = 1'b0;
    step(1);
    check("tx1_tbre_latched", 32'(tbre), 32'd0);
    check("tx1_txd_idle",     32'(txd),  32'd1);
    step(1);
    frame_t0 = cyc;
    check("tx1_tbre_reload",  32'(tbre), 32'd1);
    check("tx1_tsre_busy0",   32'(tsre), 32'd0);
    wrn = 1'b1;
    check_bits(8'hA5, 10, "tx1");
    step_to(frame_t0 + 636);
    check("tx1_tsre_busy", 32'(tsre), 32'd0);
    step_to(frame_t0 + 641);
    check("tx1_tsre_done", 32'(tsre), 32'd1);
    step(20);

    // ---- back-to-back out: 41 then 42, third write dropped
    wdata = 8'h41;
    wrn   = 1'b0;
    step(2);
    frame_t0 = cyc;
    wrn = 1'b1;
    step(1);
    wdata = 8'h42;
    wrn   = 1'b0;
    step(1);
    check("b2b_tbre_full", 32'(tbre), 32'd0);
    wrn = 1'b1;
    step(1);
    wdata = 8'h99;
    wrn   = 1'b0;
    step(1);
    wrn = 1'b1;
    step(1);
    check("b2b_tbre_still_full", 32'(tbre), 32'd0);
    check_bits(8'h41, 9, "b2b1");
    wait_txd(1'b1, 200, t1);
    check("b2b_stop_rise", 32'(txd), 32'd1);
    wait_txd(1'b0, 200, t2);
    check("b2b_start2_fall", 32'(txd), 32'd0);
    check("b2b_stop_width", 32'(t2 - t1), 32'(BIT));
    frame_t0 = t2;
    check_bits(8'h42, 10, "b2b2");
    step_to(frame_t0 + 660);
    seen_low = 1'b0;
    for (int i = 0; i < 700; i++) begin
      step(1);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    check("b2b_no_third_frame", 32'(seen_low), 32'd0);
    check("b2b_tsre_idle",      32'(tsre),     32'd1);

    // ---- single byte in: 3C
    fork
      send_rx(8'h3C, 1'b1);
      begin
        step(590);
        check("rx1_dr_early", 32'(data_ready), 32'd0);
        step(30);
        check("rx1_dr_set",   32'(data_ready), 32'd1);
      end
    join
    step(10);
    rdn = 1'b0;
    #1;
    check("rx1_oe_low", 32'(rdata_oe), 32'd1);
    step(1);
    check("rx1_rdata",     32'(rdata),      32'h3C);
    check("rx1_dr_during", 32'(data_ready), 32'd1);
    rdn = 1'b1;
    #1;
    check("rx1_oe_high", 32'(rdata_oe), 32'd0);
    step(1);
    check("rx1_dr_clear", 32'(data_ready), 32'd0);

    // ---- glitch and framing error
    step(20);
    rxd = 1'b0;
    step(12);
    rxd = 1'b1;
    step(700);
    check("glitch_no_data", 32'(data_ready), 32'd0);
    send_rx(8'hA7, 1'b0);
    step(100);
    check("frame_err_no_data", 32'(data_ready), 32'd0);
    send_rx(8'h5A, 1'b1);
    step(50);
    check("after_err_dr",    32'(data_ready), 32'd1);
    check("after_err_rdata", 32'(rdata),      32'h5A);
    do_read(v, oe);
    check("after_err_dr_clear", 32'(data_ready), 32'd0);

    // ---- overrun: 11 then 22 unread
    step(20);
    send_rx(8'h11, 1'b1);
    step(20);
    send_rx(8'h22, 1'b1);
    step(50);
    check("ovr_rdata_kept", 32'(rdata),      32'h11);
    check("ovr_flag",       32'(overrun),    32'd1);
    check("ovr_dr",         32'(data_ready), 32'd1);
    do_read(v, oe);
    check("ovr_read_val",   32'(v),          32'h11);
    check("ovr_read_oe",    32'(oe),         32'd1);
    check("ovr_dr_clear",   32'(data_ready), 32'd0);
    check("ovr_flag_clear", 32'(overrun),    32'd0);
    do_read(v, oe);
    check("stale_read_val", 32'(v),          32'h11);
    check("stale_read_dr",  32'(data_ready), 32'd0);

    // ---- reset during TX data bit 4 of 0F
    step(10);
    wdata = 8'h0F;
    wrn   = 1'b0;
    step(2);
    frame_t0 = cyc;
    wrn = 1'b1;
    step_to(frame_t0 + BIT * 5 + 30);
    check("rstmid_bit4_low", 32'(txd), 32'd0);
    memi_rst = 1'b0;
    #1;
    check("rstmid_txd",   32'(txd),        32'd1);
    check("rstmid_tbre",  32'(tbre),       32'd1);
    check("rstmid_tsre",  32'(tsre),       32'd1);
    check("rstmid_rdata", 32'(rdata),      32'h00);
    check("rstmid_dr",    32'(data_ready), 32'd0);
    step(3);
    memi_rst = 1'b1;
    step(3);
    wdata = 8'h55;
    wrn   = 1'b0;
    step(2);
    frame_t0 = cyc;
    wrn = 1'b1;
    check_bits(8'h55, 10, "post_rst");
    step_to(frame_t0 + 641);
    check("post_rst_tsre", 32'(tsre), 32'd1);

`ifdef UART_LOOPBACK_EN
    // ---- loopback: 55 received internally, txd held high
    step(10);
    loopback = 1'b1;
    step(2);
    wdata = 8'h55;
    wrn   = 1'b0;
    step(2);
    wrn = 1'b1;
    check("lb_txd_held", 32'(txd), 32'd1);
    for (int i = 0; i < 800 && data_ready !== 1'b1; i++) step(1);
    check("lb_dr",    32'(data_ready), 32'd1);
    check("lb_rdata", 32'(rdata),      32'h55);
    do_read(v, oe);
    step(100);
    loopback = 1'b0;
`endif

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
